tt_sel_seq: RTL
===============

TT_SEL_SEQ -- requirements
Module: tt_sel_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- G_X, 16, user blocks per branch.
- G_Y, 16, branches.
- MUX_MASK, all-zero, [G_Y-1:0]; bit=1 means branch absent and never selected.
- PG_DLY, 8, power-gate settle cycles, >=1.
- SYNC_STAGES, 2, pad synchronizer depth, >=2.
REQ-002 Derived widths: BK_W=max(1,clog2(G_X)), BR_W=max(1,clog2(G_Y)), AW=BR_W+BK_W; address layout {branch, block}.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- pad_sel_rst_n, in, 1, async pad; low clears selection.
- pad_sel_inc, in, 1, async pad; each rising edge advances selection.
- pad_ena, in, 1, async pad; global enable.
- tgt_addr, out, AW, requested selection.
- sel_addr, out, AW, address applied to mux tree.
- pg_ena, out, 1, power-gate enable of selected block.
- um_ena, out, 1, user-module enable.
- busy, out, 1, power sequence in progress.
REQ-004 MUX_MASK all ones, PG_DLY<1 or SYNC_STAGES<2 SHALL fail elaboration.

Function
REQ-005 Each pad input SHALL pass through its own SYNC_STAGES-flop synchronizer; sel_inc SHALL then be edge-detected, giving a one-cycle inc pulse SYNC_STAGES+1 clk edges after the pad rises.
REQ-006 FIRST = lowest branch index with MUX_MASK bit 0.
REQ-007 Synchronized sel_rst_n low SHALL load tgt_addr={FIRST,0} every cycle and suppress inc pulses; this overrides simultaneous inc.
REQ-008 Inc pulse with block<G_X-1 SHALL increment block only.
REQ-009 Inc pulse with block=G_X-1 SHALL set block=0 and branch=next higher unmasked branch, wrapping to FIRST after the highest unmasked branch; masked branches are never produced.
REQ-010 FSM states: IDLE, PWR_UP, ON, PWR_DN; pg_ena=(state!=IDLE); um_ena=(state==ON); busy=(state==PWR_UP or PWR_DN); all registered-state decodes, no input-to-output combinational path.
REQ-011 IDLE -> PWR_UP when synced ena=1; same edge SHALL load sel_addr<=tgt_addr and the delay counter with PG_DLY-1.
REQ-012 PWR_UP SHALL last exactly PG_DLY cycles, then -> ON, unless aborted.
REQ-013 PWR_UP abort (ena=0 or tgt_addr!=sel_addr) -> PWR_DN with counter reloaded to PG_DLY-1.
REQ-014 ON -> PWR_DN when ena=0 or tgt_addr!=sel_addr; counter reloaded to PG_DLY-1.
REQ-015 PWR_DN SHALL last exactly PG_DLY cycles, then -> IDLE; it is not interruptible; tgt changes during it take effect via the next IDLE->PWR_UP.
REQ-016 sel_addr SHALL change only on the IDLE->PWR_UP edge; um_ena=1 implies sel_addr==tgt_addr held for >=PG_DLY cycles.
REQ-017 Delay counter width = max(1,clog2(PG_DLY)); no wrap beyond 0.

Reset
REQ-018 rst=1 at a clk edge SHALL set all synchronizer flops to 0, state=IDLE, tgt_addr=sel_addr={FIRST,0}, counter=0; outputs read pg_ena=0, um_ena=0, busy=0 the cycle after.
REQ-019 rst mid-sequence (PWR_UP/ON/PWR_DN) SHALL apply REQ-018 immediately, without a power-down phase.
REQ-020 Pad sel_inc already high at reset release SHALL NOT produce an inc pulse.

Verification (G_X=4, G_Y=4, MUX_MASK=4'b0101, PG_DLY=3, SYNC_STAGES=2)
REQ-021 rst, pads sel_rst_n=1, ena=0 -> tgt_addr=sel_addr={1,0}=4'b0100; all flags 0.
REQ-022 From {1,0}, 4 inc pulses -> tgt={3,0}; 4 more -> tgt={1,0} (wrap); branches 0 and 2 never appear.
REQ-023 ena=1 from IDLE -> pg_ena rises 3 cycles after pad edge (sync+IDLE edge); um_ena rises exactly 3 cycles after pg_ena; busy high exactly those 3 cycles.
REQ-024 In ON, one inc -> um_ena falls, pg_ena stays 3 cycles, IDLE 1 cycle, then PWR_UP with sel_addr=new tgt.
REQ-025 inc pulse in cycle 2 of PWR_UP -> um_ena never asserts; 3-cycle PWR_DN, then re-power with new address.
REQ-026 sel_rst_n low coincident with inc -> tgt={1,0}; rst asserted in ON -> pg_ena=um_ena=0 next cycle.

Source files
------------

// File: rtl/tt_sel_seq.sv
// tt_sel_seq: pad-driven user-block selector with power-gate sequencing.
// Three asynchronous pads are synchronized. sel_rst_n/sel_inc walk a target
// address {branch, block} that never lands on a masked branch. A four-state
// FSM powers the selected block up and down around every address change.
module tt_sel_seq #(
  parameter int G_X = 16,
  parameter int G_Y = 16,
  parameter logic [G_Y-1:0] MUX_MASK = '0,
  parameter int PG_DLY = 8,
  parameter int SYNC_STAGES = 2,
  localparam int BK_W = (G_X > 1) ? $clog2(G_X) : 1,
  localparam int BR_W = (G_Y > 1) ? $clog2(G_Y) : 1,
  localparam int AW = BR_W + BK_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pad_sel_rst_n,
  input  logic          pad_sel_inc,
  input  logic          pad_ena,
  output logic [AW-1:0] tgt_addr,
  output logic [AW-1:0] sel_addr,
  output logic          pg_ena,
  output logic          um_ena,
  output logic          busy
);

  localparam int CNT_W = (PG_DLY > 1) ? $clog2(PG_DLY) : 1;

  // Lowest branch that is physically present.
  function automatic int first_branch();
    int r;
    r = 0;
    for (int i = G_Y - 1; i >= 0; i--) begin
      if (!MUX_MASK[i]) r = i;
    end
    return r;
  endfunction

  localparam int FIRST = first_branch();
  localparam logic [AW-1:0] RST_ADDR = {BR_W'(FIRST), {BK_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PG_DLY - 1);
  localparam logic [BK_W-1:0] BLK_LAST = BK_W'(G_X - 1);

  // Parameter sanity: an all-masked tree has nothing to select, and the
  // counter and synchronizer need a minimum depth to be meaningful.
  if (MUX_MASK == {G_Y{1'b1}}) begin : g_bad_mask
    $error("tt_sel_seq: MUX_MASK masks every branch");
  end
  if (PG_DLY < 1) begin : g_bad_dly
    $error("tt_sel_seq: PG_DLY must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tt_sel_seq: SYNC_STAGES must be at least 2");
  end

  // Next present branch strictly above cur, wrapping to FIRST.
  function automatic logic [BR_W-1:0] next_branch(input logic [BR_W-1:0] cur);
    logic [BR_W-1:0] r;
    r = BR_W'(FIRST);
    for (int i = G_Y - 1; i >= 0; i--) begin
      if (!MUX_MASK[i] && (i > int'(cur))) r = BR_W'(i);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Pad synchronizers: index 0 = sel_rst_n, 1 = sel_inc, 2 = ena
  // ---------------------------------------------------------------------
  logic [2:0]                  pad_vec;
  logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic                        sel_rst_n_s, inc_s, ena_s;

  assign pad_vec     = {pad_ena, pad_sel_inc, pad_sel_rst_n};
  assign sel_rst_n_s = sync_q[0][SYNC_STAGES-1];
  assign inc_s       = sync_q[1][SYNC_STAGES-1];
  assign ena_s       = sync_q[2][SYNC_STAGES-1];

  // Shift each pad into its own synchronizer chain.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pad_vec[i]};
    end
  end

  // ---------------------------------------------------------------------
  // Increment edge detector. arm_q fills with ones after reset so that the
  // previous-value flop only counts once it holds a genuine post-reset
  // sample; a pad already high at reset release then yields no pulse.
  // ---------------------------------------------------------------------
  logic                   inc_prev_q, inc_prev_d;
  logic [SYNC_STAGES:0]   arm_q, arm_d;
  logic                   inc_pulse;

  // Track the synced inc level and the arming shift register.
  always_comb begin
    inc_prev_d = inc_s;
    arm_d      = {arm_q[SYNC_STAGES-1:0], 1'b1};
    inc_pulse  = arm_q[SYNC_STAGES] & inc_s & ~inc_prev_q & sel_rst_n_s;
  end

  // ---------------------------------------------------------------------
  // Target address walker
  // ---------------------------------------------------------------------
  logic [AW-1:0]   tgt_q, tgt_d;
  logic [BR_W-1:0] tgt_br;
  logic [BK_W-1:0] tgt_blk;

  assign tgt_br  = tgt_q[AW-1:BK_W];
  assign tgt_blk = tgt_q[BK_W-1:0];

  // Selection clear dominates; otherwise step block, then branch.
  always_comb begin
    tgt_d = tgt_q;
    if (!sel_rst_n_s) begin
      tgt_d = RST_ADDR;
    end else if (inc_pulse) begin
      if (tgt_blk == BLK_LAST) begin
        tgt_d = {next_branch(tgt_br), {BK_W{1'b0}}};
      end else begin
        tgt_d = {tgt_br, tgt_blk + BK_W'(1)};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Power sequencing FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PWR_UP = 2'd1,
    S_ON     = 2'd2,
    S_PWR_DN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    sel_q, sel_d;
  logic             abort;

  // Next state, settle counter and applied address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    abort   = !ena_s || (tgt_q != sel_q);
    case (state_q)
      S_IDLE: begin
        if (ena_s) begin
          state_d = S_PWR_UP;
          sel_d   = tgt_q;
          cnt_d   = CNT_LOAD;
        end
      end
      S_PWR_UP: begin
        if (abort) begin
          state_d = S_PWR_DN;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ON: begin
        if (abort) begin
          state_d = S_PWR_DN;
          cnt_d   = CNT_LOAD;
        end
      end
      S_PWR_DN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // All state registers; reset drops straight to IDLE with no power-down.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      inc_prev_q <= 1'b0;
      arm_q      <= '0;
      tgt_q      <= RST_ADDR;
      sel_q      <= RST_ADDR;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      inc_prev_q <= inc_prev_d;
      arm_q      <= arm_d;
      tgt_q      <= tgt_d;
      sel_q      <= sel_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs decode registered state only.
  assign tgt_addr = tgt_q;
  assign sel_addr = sel_q;
  assign pg_ena   = (state_q != S_IDLE);
  assign um_ena   = (state_q == S_ON);
  assign busy     = (state_q == S_PWR_UP) || (state_q == S_PWR_DN);

endmodule
